// File: rtl/game_pkg.sv
// Shared types and sizes for the collision frame statistics block.
// Optional bounding-box fields are controlled by COLLISION_STATS_BBOX_EN.
package game_pkg;

    localparam int unsigned PIX_CNT_W         = 20;
    localparam int unsigned HCOUNT_W          = 11;
    localparam int unsigned VCOUNT_W          = 10;
    localparam int unsigned FRAME_ID_W        = 8;
    localparam int unsigned DEPTH_W           = 8;
    localparam int unsigned DROP_W            = 8;
    localparam int unsigned DEF_SCREEN_WIDTH  = 1280;
    localparam int unsigned DEF_SCREEN_HEIGHT = 720;

`ifdef COLLISION_STATS_BBOX_EN
    typedef struct packed {
        logic                bbox_valid;
        logic [HCOUNT_W-1:0] hmin;
        logic [HCOUNT_W-1:0] hmax;
        logic [VCOUNT_W-1:0] vmin;
        logic [VCOUNT_W-1:0] vmax;
    } bbox_t;

    // Empty box: min at the top of the range so the first hit replaces it.
    localparam bbox_t BBOX_INIT = '{bbox_valid: 1'b0,
                                    hmin: {HCOUNT_W{1'b1}}, hmax: '0,
                                    vmin: {VCOUNT_W{1'b1}}, vmax: '0};
`endif

    typedef struct packed {
        logic [FRAME_ID_W-1:0] frame_id;
        logic [DEPTH_W-1:0]    wall_depth;
        logic [PIX_CNT_W-1:0]  wall_cnt;
        logic [PIX_CNT_W-1:0]  person_cnt;
        logic [PIX_CNT_W-1:0]  coll_cnt;
        logic                  hot;
`ifdef COLLISION_STATS_BBOX_EN
        bbox_t                 bbox;
`endif
    } frame_stats_t;

endpackage

// File: rtl/pixel_accumulator.sv
// Per-frame wall/person/collision pixel counters with frame-end detection.
// Collision bounding box added when COLLISION_STATS_BBOX_EN is defined.
module pixel_accumulator
    import game_pkg::*;
#(
    parameter int unsigned SCREEN_WIDTH  = DEF_SCREEN_WIDTH,
    parameter int unsigned SCREEN_HEIGHT = DEF_SCREEN_HEIGHT
) (
    input  logic                 clk_in,
    input  logic                 rst_n_in,
    input  logic [HCOUNT_W-1:0]  hcount_in,
    input  logic [VCOUNT_W-1:0]  vcount_in,
    input  logic                 data_valid_in,
    input  logic                 is_wall_in,
    input  logic                 is_person_in,
    input  logic                 is_collision_in,
    output logic                 frame_end_c_o,
    output logic [PIX_CNT_W-1:0] wall_final_c_o,
    output logic [PIX_CNT_W-1:0] person_final_c_o,
    output logic [PIX_CNT_W-1:0] coll_final_c_o
`ifdef COLLISION_STATS_BBOX_EN
    ,
    output bbox_t                bbox_final_c_o
`endif
);

    logic [PIX_CNT_W-1:0] wall_q, wall_d;
    logic [PIX_CNT_W-1:0] person_q, person_d;
    logic [PIX_CNT_W-1:0] coll_q, coll_d;

    assign frame_end_c_o = data_valid_in
                        && (hcount_in == HCOUNT_W'(SCREEN_WIDTH - 1))
                        && (vcount_in == VCOUNT_W'(SCREEN_HEIGHT - 1));

    // Final values include the current pixel so the frame-end pixel is counted.
    always_comb begin
        wall_final_c_o   = wall_q   + PIX_CNT_W'(data_valid_in && is_wall_in);
        person_final_c_o = person_q + PIX_CNT_W'(data_valid_in && is_person_in);
        coll_final_c_o   = coll_q   + PIX_CNT_W'(data_valid_in && is_collision_in);
        wall_d   = frame_end_c_o ? '0 : wall_final_c_o;
        person_d = frame_end_c_o ? '0 : person_final_c_o;
        coll_d   = frame_end_c_o ? '0 : coll_final_c_o;
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            wall_q   <= '0;
            person_q <= '0;
            coll_q   <= '0;
        end else begin
            wall_q   <= wall_d;
            person_q <= person_d;
            coll_q   <= coll_d;
        end
    end

`ifdef COLLISION_STATS_BBOX_EN
    bbox_t bbox_q, bbox_d;

    always_comb begin
        bbox_final_c_o = bbox_q;
        if (data_valid_in && is_collision_in) begin
            bbox_final_c_o.bbox_valid = 1'b1;
            if (hcount_in < bbox_q.hmin) bbox_final_c_o.hmin = hcount_in;
            if (hcount_in > bbox_q.hmax) bbox_final_c_o.hmax = hcount_in;
            if (vcount_in < bbox_q.vmin) bbox_final_c_o.vmin = vcount_in;
            if (vcount_in > bbox_q.vmax) bbox_final_c_o.vmax = vcount_in;
        end
        bbox_d = frame_end_c_o ? BBOX_INIT : bbox_final_c_o;
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) bbox_q <= BBOX_INIT;
        else           bbox_q <= bbox_d;
    end
`endif

endmodule

// File: rtl/collision_frame_stats.sv
// Per-frame collision summary with valid/ready output, round peak and hot streak.
// Bounding-box reporting is enabled by COLLISION_STATS_BBOX_EN.
module collision_frame_stats
    import game_pkg::*;
#(
    parameter int unsigned SCREEN_WIDTH        = DEF_SCREEN_WIDTH,
    parameter int unsigned SCREEN_HEIGHT       = DEF_SCREEN_HEIGHT,
    parameter int unsigned COLLISION_THRESHOLD = 65536,
    parameter int unsigned STREAK_BITS         = 4
) (
    input  logic                   clk_in,
    input  logic                   rst_n_in,
    input  logic [HCOUNT_W-1:0]    hcount_in,
    input  logic [VCOUNT_W-1:0]    vcount_in,
    input  logic                   data_valid_in,
    input  logic                   is_wall_in,
    input  logic                   is_person_in,
    input  logic                   is_collision_in,
    input  logic [DEPTH_W-1:0]     wall_depth_in,
    input  logic                   round_start_in,
    output logic                   stats_valid_out,
    input  logic                   stats_ready_in,
    output frame_stats_t           stats_out,
    output logic [PIX_CNT_W-1:0]   peak_collisions_out,
    output logic [STREAK_BITS-1:0] hot_streak_out,
    output logic [DROP_W-1:0]      dropped_frames_out
);

    logic                 frame_end_c;
    logic [PIX_CNT_W-1:0] wall_fin_c, person_fin_c, coll_fin_c;
`ifdef COLLISION_STATS_BBOX_EN
    bbox_t                bbox_fin_c;
`endif

    pixel_accumulator #(
        .SCREEN_WIDTH  (SCREEN_WIDTH),
        .SCREEN_HEIGHT (SCREEN_HEIGHT)
    ) u_acc (
        .clk_in           (clk_in),
        .rst_n_in         (rst_n_in),
        .hcount_in        (hcount_in),
        .vcount_in        (vcount_in),
        .data_valid_in    (data_valid_in),
        .is_wall_in       (is_wall_in),
        .is_person_in     (is_person_in),
        .is_collision_in  (is_collision_in),
        .frame_end_c_o    (frame_end_c),
        .wall_final_c_o   (wall_fin_c),
        .person_final_c_o (person_fin_c),
        .coll_final_c_o   (coll_fin_c)
`ifdef COLLISION_STATS_BBOX_EN
        ,
        .bbox_final_c_o   (bbox_fin_c)
`endif
    );

    frame_stats_t           stats_q, stats_d, snap_c;
    logic                   valid_q, valid_d;
    logic [FRAME_ID_W-1:0]  frame_id_q, frame_id_d;
    logic [PIX_CNT_W-1:0]   peak_q, peak_d;
    logic [STREAK_BITS-1:0] streak_q, streak_d;
    logic [DROP_W-1:0]      dropped_q, dropped_d;

    always_comb begin
        snap_c            = '0;
        snap_c.frame_id   = frame_id_q;
        snap_c.wall_depth = wall_depth_in;
        snap_c.wall_cnt   = wall_fin_c;
        snap_c.person_cnt = person_fin_c;
        snap_c.coll_cnt   = coll_fin_c;
        snap_c.hot        = (coll_fin_c >= PIX_CNT_W'(COLLISION_THRESHOLD));
`ifdef COLLISION_STATS_BBOX_EN
        snap_c.bbox       = bbox_fin_c;
`endif

        stats_d    = stats_q;
        valid_d    = valid_q;
        frame_id_d = frame_id_q;
        peak_d     = peak_q;
        streak_d   = streak_q;
        dropped_d  = dropped_q;

        if (valid_q && stats_ready_in) valid_d = 1'b0;
        if (round_start_in) begin
            peak_d   = '0;
            streak_d = '0;
        end

        // A snapshot loads only if the holding register is empty or draining now.
        if (frame_end_c) begin
            frame_id_d = frame_id_q + FRAME_ID_W'(1);
            if (!valid_q || stats_ready_in) begin
                stats_d = snap_c;
                valid_d = 1'b1;
            end else if (dropped_q != {DROP_W{1'b1}}) begin
                dropped_d = dropped_q + DROP_W'(1);
            end

            if (round_start_in || (coll_fin_c > peak_q)) peak_d = coll_fin_c;

            if (!snap_c.hot)                         streak_d = '0;
            else if (round_start_in)                 streak_d = STREAK_BITS'(1);
            else if (streak_q != {STREAK_BITS{1'b1}}) streak_d = streak_q + STREAK_BITS'(1);
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            stats_q    <= '0;
            valid_q    <= 1'b0;
            frame_id_q <= '0;
            peak_q     <= '0;
            streak_q   <= '0;
            dropped_q  <= '0;
        end else begin
            stats_q    <= stats_d;
            valid_q    <= valid_d;
            frame_id_q <= frame_id_d;
            peak_q     <= peak_d;
            streak_q   <= streak_d;
            dropped_q  <= dropped_d;
        end
    end

    assign stats_out           = stats_q;
    assign stats_valid_out     = valid_q;
    assign peak_collisions_out = peak_q;
    assign hot_streak_out      = streak_q;
    assign dropped_frames_out  = dropped_q;

endmodule

// File: tb/tb_collision_frame_stats.sv
// Directed self-checking bench for collision_frame_stats on an 8x4 screen, threshold 5.
// Bounding-box checks are compiled when COLLISION_STATS_BBOX_EN is defined.
module tb_collision_frame_stats;
    import game_pkg::*;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [10:0]          hcount;
    logic [9:0]           vcount;
    logic                 dv, is_wall, is_person, is_coll;
    logic [7:0]           wall_depth;
    logic                 round_start;
    logic                 valid, ready;
    frame_stats_t         stats;
    logic [19:0]          peak;
    logic [3:0]           streak;
    logic [7:0]           dropped;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;
    int exp_id  = 0;
    int held_id;
    int t2_nc[3]     = '{3, 7, 2};
    int t2_peak[3]   = '{3, 7, 7};
    int t2_streak[3] = '{0, 1, 0};

    always #5 clk = ~clk;

    collision_frame_stats #(
        .SCREEN_WIDTH        (8),
        .SCREEN_HEIGHT       (4),
        .COLLISION_THRESHOLD (5),
        .STREAK_BITS         (4)
    ) dut (
        .clk_in              (clk),
        .rst_n_in            (rst_n),
        .hcount_in           (hcount),
        .vcount_in           (vcount),
        .data_valid_in       (dv),
        .is_wall_in          (is_wall),
        .is_person_in        (is_person),
        .is_collision_in     (is_coll),
        .wall_depth_in       (wall_depth),
        .round_start_in      (round_start),
        .stats_valid_out     (valid),
        .stats_ready_in      (ready),
        .stats_out           (stats),
        .peak_collisions_out (peak),
        .hot_streak_out      (streak),
        .dropped_frames_out  (dropped)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic rs);
        round_start = rs;
        step();
        round_start = 1'b0;
    endtask

    // Pixels start..stop of an 8x4 frame; collisions are the last nc pixels,
    // wall/person the first nw/np. Frame end fires only when stop == 31.
    task automatic run_frame(input int start, input int stop, input int nc, input int nw,
                             input int np, input logic [7:0] depth, input logic rs_last,
                             input logic rdy_last);
        int n;
        int k;
        n = stop - start + 1;
        for (int idx = start; idx <= stop; idx++) begin
            k          = idx - start;
            hcount     = 11'(idx % 8);
            vcount     = 10'(idx / 8);
            dv         = 1'b1;
            is_coll    = (k >= n - nc);
            is_wall    = (k < nw);
            is_person  = (k < np);
            wall_depth = (idx == stop) ? depth : 8'h11;
            if (idx == stop) begin
                round_start = rs_last;
                ready       = rdy_last;
            end
            step();
        end
        dv = 1'b0; is_coll = 1'b0; is_wall = 1'b0; is_person = 1'b0;
        round_start = 1'b0;
        if (stop == 31) exp_id++;
    endtask

    initial begin
        rst_n = 1'b0; hcount = '0; vcount = '0; dv = 1'b0;
        is_wall = 1'b0; is_person = 1'b0; is_coll = 1'b0;
        wall_depth = '0; round_start = 1'b0; ready = 1'b0;
        step(); step();
        chk("rst_valid",   32'(valid),   32'd0);
        chk("rst_id",      32'(stats.frame_id), 32'd0);
        chk("rst_coll",    32'(stats.coll_cnt), 32'd0);
        chk("rst_peak",    32'(peak),    32'd0);
        chk("rst_streak",  32'(streak),  32'd0);
        chk("rst_dropped", 32'(dropped), 32'd0);
        rst_n = 1'b1;
        step();

        // Flags asserted at the frame-end coordinate with data_valid low are ignored.
        hcount = 11'd7; vcount = 10'd3;
        is_wall = 1'b1; is_person = 1'b1; is_coll = 1'b1;
        step(); step(); step();
        is_wall = 1'b0; is_person = 1'b0; is_coll = 1'b0;
        chk("invalid_no_frame", 32'(valid), 32'd0);

        ready = 1'b1;
        run_frame(0, 31, 6, 10, 12, 8'hA7, 1'b0, 1'b1);
        chk("t1_valid",  32'(valid),            32'd1);
        chk("t1_id",     32'(stats.frame_id),   32'd0);
        chk("t1_depth",  32'(stats.wall_depth), 32'hA7);
        chk("t1_wall",   32'(stats.wall_cnt),   32'd10);
        chk("t1_person", 32'(stats.person_cnt), 32'd12);
        chk("t1_coll",   32'(stats.coll_cnt),   32'd6);
        chk("t1_hot",    32'(stats.hot),        32'd1);
        chk("t1_streak", 32'(streak),           32'd1);
        chk("t1_peak",   32'(peak),             32'd6);

        idle(1'b1);
        chk("rs_valid_drain", 32'(valid),  32'd0);
        chk("rs_peak",        32'(peak),   32'd0);
        chk("rs_streak",      32'(streak), 32'd0);

        for (int i = 0; i < 3; i++) begin
            run_frame(0, 31, t2_nc[i], 0, 0, 8'h00, 1'b0, 1'b1);
            chk("t2_coll",   32'(stats.coll_cnt), 32'(t2_nc[i]));
            chk("t2_id",     32'(stats.frame_id), 32'(i + 1));
            chk("t2_peak",   32'(peak),           32'(t2_peak[i]));
            chk("t2_streak", 32'(streak),         32'(t2_streak[i]));
        end
        idle(1'b0);
        chk("t2_drain", 32'(valid), 32'd0);

        // Backpressure: first snapshot is held, the next two are dropped.
        ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            run_frame(0, 31, 1, 0, 0, 8'h00, 1'b0, 1'b0);
            chk("t3_valid",   32'(valid),          32'd1);
            chk("t3_id_held", 32'(stats.frame_id), 32'd4);
            chk("t3_dropped", 32'(dropped),        32'(i));
        end
        ready = 1'b1;
        idle(1'b0);
        chk("t3_drain",   32'(valid),   32'd0);
        chk("t3_dropped", 32'(dropped), 32'd2);

        // Snapshot coinciding with a transfer replaces the record without a drop.
        ready = 1'b0;
        run_frame(0, 31, 1, 0, 0, 8'h00, 1'b0, 1'b0);
        chk("t4_id_a", 32'(stats.frame_id), 32'd7);
        run_frame(0, 31, 2, 0, 0, 8'h00, 1'b0, 1'b1);
        chk("t4_valid",   32'(valid),          32'd1);
        chk("t4_id_b",    32'(stats.frame_id), 32'd8);
        chk("t4_coll_b",  32'(stats.coll_cnt), 32'd2);
        chk("t4_dropped", 32'(dropped),        32'd2);
        idle(1'b0);
        chk("t4_drain", 32'(valid), 32'd0);

        idle(1'b1);
        chk("t5_clear", 32'(peak), 32'd0);
        run_frame(0, 31, 9, 0, 0, 8'h00, 1'b0, 1'b1);
        chk("t5_peak9",   32'(peak),   32'd9);
        chk("t5_streak1", 32'(streak), 32'd1);
        run_frame(0, 31, 6, 0, 0, 8'h00, 1'b1, 1'b1);
        chk("t5_rs_hot_peak",   32'(peak),   32'd6);
        chk("t5_rs_hot_streak", 32'(streak), 32'd1);
        run_frame(0, 31, 4, 0, 0, 8'h00, 1'b1, 1'b1);
        chk("t5_rs_peak4",  32'(peak),      32'd4);
        chk("t5_streak0",   32'(streak),    32'd0);
        chk("t5_hot4",      32'(stats.hot), 32'd0);

        for (int i = 0; i < 16; i++) begin
            run_frame(0, 31, 5, 0, 0, 8'h00, 1'b0, 1'b1);
            if (i == 0)  chk("thr_boundary_hot", 32'(stats.hot), 32'd1);
            if (i == 14) chk("streak_15",        32'(streak),    32'd15);
        end
        chk("streak_sat", 32'(streak), 32'd15);
        chk("peak5",      32'(peak),   32'd5);

        held_id = exp_id - 1;
        ready = 1'b0;
        for (int i = 0; i < 258; i++) run_frame(0, 31, 0, 0, 0, 8'h00, 1'b0, 1'b0);
        chk("dropped_sat",  32'(dropped),        32'd255);
        chk("sat_id_held",  32'(stats.frame_id), 32'(8'(held_id)));
        chk("sat_streak0",  32'(streak),         32'd0);
        ready = 1'b1;
        idle(1'b0);
        chk("sat_drain", 32'(valid), 32'd0);
        run_frame(0, 31, 1, 0, 0, 8'h00, 1'b0, 1'b1);
        chk("id_wrap", 32'(stats.frame_id), 32'd30);

        // Asynchronous reset mid-frame with a record held and nonzero counters.
        ready = 1'b0;
        run_frame(0, 15, 8, 8, 8, 8'h00, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("arst_valid",   32'(valid),            32'd0);
        chk("arst_id",      32'(stats.frame_id),   32'd0);
        chk("arst_wall",    32'(stats.wall_cnt),   32'd0);
        chk("arst_peak",    32'(peak),             32'd0);
        chk("arst_dropped", 32'(dropped),          32'd0);
        step();
        rst_n = 1'b1;
        exp_id = 0;
        ready = 1'b1;
        run_frame(16, 31, 3, 4, 5, 8'h3C, 1'b0, 1'b1);
        chk("post_rst_id",     32'(stats.frame_id),   32'd0);
        chk("post_rst_coll",   32'(stats.coll_cnt),   32'd3);
        chk("post_rst_wall",   32'(stats.wall_cnt),   32'd4);
        chk("post_rst_person", 32'(stats.person_cnt), 32'd5);
        chk("post_rst_depth",  32'(stats.wall_depth), 32'h3C);

`ifdef COLLISION_STATS_BBOX_EN
        for (int idx = 0; idx < 32; idx++) begin
            hcount  = 11'(idx % 8);
            vcount  = 10'(idx / 8);
            dv      = 1'b1;
            is_coll = ((idx % 8) == 2 && (idx / 8) == 1) || ((idx % 8) == 5 && (idx / 8) == 3);
            step();
        end
        dv = 1'b0; is_coll = 1'b0;
        chk("bbox_valid", 32'(stats.bbox.bbox_valid), 32'd1);
        chk("bbox_hmin",  32'(stats.bbox.hmin),       32'd2);
        chk("bbox_hmax",  32'(stats.bbox.hmax),       32'd5);
        chk("bbox_vmin",  32'(stats.bbox.vmin),       32'd1);
        chk("bbox_vmax",  32'(stats.bbox.vmax),       32'd3);
        run_frame(0, 31, 0, 0, 0, 8'h00, 1'b0, 1'b1);
        chk("bbox_empty_valid", 32'(stats.bbox.bbox_valid), 32'd0);
        chk("bbox_empty_hmin",  32'(stats.bbox.hmin),       32'd2047);
        chk("bbox_empty_vmin",  32'(stats.bbox.vmin),       32'd1023);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/collision_frame_stats.md
Name: collision_frame_stats

Overview:
- Sits directly downstream of the game logic controller; consumes its per-pixel registered outputs (is_wall, is_person, is_collision, hcount, vcount, data_valid, wall_depth).
- Accumulates per-frame pixel counts and snapshots them at frame end into one summary record.
- Publishes the record over a valid/ready stream to the HUD/UART reporter.
- Tracks the per-round peak collision count and a consecutive-over-threshold frame streak.

Parameters:
- SCREEN_WIDTH, 1280, active pixels per line.
- SCREEN_HEIGHT, 720, active lines per frame.
- COLLISION_THRESHOLD, 65536, a frame is "hot" when its collision count is at least this value.
- STREAK_BITS, 4, width of the saturating hot-frame streak counter.

Ports:
- clk_in  input  1  pixel clock.
- rst_n_in  input  1  asynchronous, active-low reset.
- hcount_in  input  11  pixel column.
- vcount_in  input  10  pixel row.
- data_valid_in  input  1  pixel qualifier.
- is_wall_in  input  1  wall pixel.
- is_person_in  input  1  person pixel.
- is_collision_in  input  1  wall and person pixel.
- wall_depth_in  input  8  current wall depth.
- round_start_in  input  1  single-cycle pulse at the start of each round.
- stats_valid_out  output  1  summary record available.
- stats_ready_in  input  1  consumer accepts the record.
- stats_out  output  frame_stats_t  summary record (see Decomposition).
- peak_collisions_out  output  20  maximum collision count of any frame in the current round.
- hot_streak_out  output  STREAK_BITS  consecutive hot frames, saturating.
- dropped_frames_out  output  8  summaries lost to backpressure, saturating at 255.

Behaviour:
- Reset: all counters, outputs and the record register go to 0; stats_valid_out=0; frame_id=0.
- Counting: on each cycle with data_valid_in=1, increment wall_cnt, person_cnt and coll_cnt by their respective flag. Each count is 20 bits (921600 < 2^20). Cycles with data_valid_in=0 are ignored.
- Frame end (frame_end) is data_valid_in && hcount_in==SCREEN_WIDTH-1 && vcount_in==SCREEN_HEIGHT-1.
  - The frame-end pixel is included in the snapshot.
  - Accumulators restart at 0 on the same edge, so the next frame starts clean.
- Snapshot, registered on the frame_end edge; it appears 1 cycle after the frame_end pixel:
  - frame_id, 8-bit, increments per snapshot and wraps 255->0.
  - wall_depth_in, sampled at frame_end.
  - wall_cnt, person_cnt, coll_cnt.
  - hot = coll_cnt_final >= COLLISION_THRESHOLD.
- Output handshake, single-entry holding register:
  - A transfer occurs when valid && ready.
  - stats_out is stable while valid && !ready.
  - New snapshot while empty, or while a transfer happens the same cycle: load the register; valid=1.
  - New snapshot while valid && !ready: discard the new snapshot, keep the old one, dropped_frames_out+=1 (saturating). frame_id still increments, so the consumer sees the gap.
- Peak tracking: at each snapshot, peak = max(peak, coll_cnt_final).
  - round_start_in clears peak to 0.
  - If round_start_in and a snapshot coincide, peak = coll_cnt_final.
- Streak: at each snapshot, a hot frame gives streak = sat_inc(streak); a non-hot frame gives streak = 0. round_start_in clears streak; a coincident hot snapshot gives streak = 1.
- Reset mid-frame: partial counts are discarded; the first summary after reset covers only the pixels seen since reset.
- A stall of the consumer never stalls pixel counting.

Optional Feature:
- Macro: COLLISION_STATS_BBOX_EN.
- Defined:
  - Track the collision bounding box per frame: hmin/hmax (11 b), vmin/vmax (10 b), plus bbox_valid (any collision seen).
  - Initialise to hmin=2047, vmin=1023, hmax=0, vmax=0 at frame start; update on each collision pixel, including the frame-end pixel.
  - The box is appended to frame_stats_t.
- Undefined: the fields are absent from the struct; no box logic is generated.

Decomposition:
- game_pkg:
  - frame_stats_t packed struct: frame_id, wall_depth, wall_cnt, person_cnt, coll_cnt, hot, plus bbox fields under the macro.
  - PIX_CNT_W=20.
  - Screen-size defaults.
- Sub-module pixel_accumulator:
  - Holds the three per-frame counters (plus bbox).
  - Exposes the final values and a frame_end strobe.
  - The top level keeps the handshake, peak and streak logic.

Test Plan:
- W=8,H=4,THRESHOLD=5, ready=1; a frame with 6 collision, 10 wall, 12 person pixels, the last pixel a collision -> 1 cycle after frame_end: valid=1, coll=6, wall=10, person=12, hot=1, frame_id=0, hot_streak=1.
- Three back-to-back frames with coll = 3, 7, 2 and no round_start -> peak = 3, then 7, then 7; streak = 0, 1, 0.
- ready=0 across 3 frames -> stats_out keeps frame_id=0 unchanged; dropped=2; raise ready -> one transfer, then valid=0.
- Snapshot and transfer in the same cycle (valid=1, ready=1 at snapshot) -> register loads the new frame_id; valid stays 1; dropped unchanged.
- round_start_in coincident with a snapshot of coll=4 after peak=9 -> peak=4.
- Assert rst_n_in mid-frame for 1 cycle -> all outputs 0 immediately (async); next summary counts only post-reset pixels; frame_id=0. With BBOX_EN: collisions at (2,1) and (5,3) -> hmin=2, hmax=5, vmin=1, vmax=3.
